// File: rtl/neopixel_receiver.sv
// WS2812-style one-wire receiver: decodes 24-bit pixel words from high-pulse widths,
// detects the latch gap and forwards the bits after the first word downstream.
module neopixel_receiver #(
    parameter int unsigned THRESH       = 27,
    parameter int unsigned MIN_HIGH     = 5,
    parameter int unsigned MAX_HIGH     = 100,
    parameter int unsigned RESET_CYCLES = 2500,
    parameter int unsigned CW           = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neopixel_in,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_end,
    output logic        error,
    output logic        neopixel_out
);

    localparam int unsigned BW = 5;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, WAIT_GAP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, s_q, prev_q;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          captured_q, captured_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   pixel_data_q, pixel_data_d;
    logic          valid_pend_q, valid_pend_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic          frame_end_q, frame_end_d;
    logic          error_q, error_d;
    logic          neopixel_out_q, neopixel_out_d;

    logic          rise, fall, bit_v;
    logic [CW-1:0] low_inc, high_inc;

    assign rise     = s_q & ~prev_q;
    assign fall     = ~s_q & prev_q;
    assign low_inc  = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + CW'(1);
    assign high_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CW'(1);

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        high_cnt_d     = high_cnt_q;
        low_cnt_d      = low_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        captured_d     = captured_q;
        shift_d        = shift_q;
        pixel_data_d   = pixel_data_q;
        valid_pend_d   = 1'b0;
        pixel_valid_d  = valid_pend_q;
        frame_end_d    = 1'b0;
        error_d        = 1'b0;
        bit_v          = 1'b0;

        case (state_q)
            IDLE, LOW: begin
                if (rise) begin
                    high_cnt_d = CW'(1);
                    low_cnt_d  = '0;
                    state_d    = HIGH;
                end else if (!s_q) begin
                    low_cnt_d = low_inc;
                    if (state_q == LOW && low_inc == CW'(RESET_CYCLES)) begin
                        frame_end_d = (bit_cnt_q != '0) || captured_q;
                        error_d     = (bit_cnt_q != '0) && !captured_q;
                        bit_cnt_d   = '0;
                        captured_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            HIGH: begin
                if (s_q) begin
                    high_cnt_d = high_inc;
                    if (high_inc > CW'(MAX_HIGH)) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        low_cnt_d = '0;
                        state_d   = WAIT_GAP;
                    end
                end else if (fall) begin
                    state_d = LOW;
                    if (high_cnt_q < CW'(MIN_HIGH)) begin
                        low_cnt_d = '0;
                    end else begin
                        low_cnt_d = CW'(1);
                        bit_v     = (high_cnt_q >= CW'(THRESH));
                        // Once a word is captured, further bits are only forwarded
                        if (!captured_q) begin
                            shift_d = {shift_q[22:0], bit_v};
                            if (bit_cnt_q == BW'(23)) begin
                                pixel_data_d = shift_d;
                                valid_pend_d = 1'b1;
                                captured_d   = 1'b1;
                                bit_cnt_d    = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BW'(1);
                            end
                        end
                    end
                end
            end
            WAIT_GAP: begin
                if (s_q) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc == CW'(RESET_CYCLES)) begin
                        captured_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        neopixel_out_d = s_q & captured_d & (state_d != WAIT_GAP);
    end

    // Synchronizer resets high so a line already high at reset release is not seen as a rise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b1;
            s_q            <= 1'b1;
            prev_q         <= 1'b1;
            state_q        <= IDLE;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            captured_q     <= 1'b0;
            shift_q        <= '0;
            pixel_data_q   <= '0;
            valid_pend_q   <= 1'b0;
            pixel_valid_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            error_q        <= 1'b0;
            neopixel_out_q <= 1'b0;
        end else begin
            sync1_q        <= neopixel_in;
            s_q            <= sync1_q;
            prev_q         <= s_q;
            state_q        <= state_d;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            captured_q     <= captured_d;
            shift_q        <= shift_d;
            pixel_data_q   <= pixel_data_d;
            valid_pend_q   <= valid_pend_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_end_q    <= frame_end_d;
            error_q        <= error_d;
            neopixel_out_q <= neopixel_out_d;
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_end    = frame_end_q;
    assign error        = error_q;
    assign neopixel_out = neopixel_out_q;

endmodule

// File: tb/tb_neopixel_receiver.sv
// Bench for neopixel_receiver: drives pulse trains and checks against a protocol-level model.
module tb_neopixel_receiver;

    localparam int unsigned THRESH = 27, MIN_HIGH = 5, MAX_HIGH = 100, RESET_CYCLES = 2500;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        neopixel_in = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid, frame_end, error, neopixel_out;

    neopixel_receiver #(.THRESH(THRESH), .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH),
                        .RESET_CYCLES(RESET_CYCLES), .CW(12)) dut (
        .clock(clock), .reset(reset), .neopixel_in(neopixel_in),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .frame_end(frame_end),
        .error(error), .neopixel_out(neopixel_out));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int rise_cyc = 0, fall_cyc = 0;

    // Output monitor
    int pv_cnt = 0, fe_cnt = 0, err_cnt = 0, coinc_cnt = 0, multi_cnt = 0;
    int pv_lat = 0, fe_lat = 0, err_lat = 0, out_run = 0;
    logic [23:0] pv_data = '0;
    logic pv_p = 1'b0, fe_p = 1'b0, er_p = 1'b0, out_p = 1'b0;
    int out_q[$], dly_q[$];

    always @(negedge clock) begin
        pv_p  <= pixel_valid;
        fe_p  <= frame_end;
        er_p  <= error;
        out_p <= neopixel_out;
        if (pixel_valid) begin
            pv_cnt  <= pv_cnt + 1;
            pv_data <= pixel_data;
            pv_lat  <= cyc - fall_cyc;
        end
        if (frame_end) begin
            fe_cnt <= fe_cnt + 1;
            fe_lat <= cyc - fall_cyc;
        end
        if (error) begin
            err_cnt <= err_cnt + 1;
            err_lat <= cyc - rise_cyc;
        end
        if (frame_end && error) coinc_cnt <= coinc_cnt + 1;
        if ((pixel_valid && pv_p) || (frame_end && fe_p) || (error && er_p)) multi_cnt <= multi_cnt + 1;
        if (neopixel_out) begin
            out_run <= out_run + 1;
            if (!out_p) dly_q.push_back(cyc - rise_cyc);
        end else if (out_run != 0) begin
            out_q.push_back(out_run);
            out_run <= 0;
        end
    end

    // Protocol-level reference model
    int m_bits = 0;
    logic m_capt = 1'b0, m_wait = 1'b0;
    logic [23:0] m_word = '0, exp_data = '0;
    int exp_pv = 0, exp_fe = 0, exp_err = 0, exp_coinc = 0;
    int exp_fwd[$];

    task automatic model_pulse(input int h);
        if (h > int'(MAX_HIGH)) begin
            exp_err++; m_bits = 0; m_wait = 1'b1;
        end else if (!m_wait) begin
            if (m_capt) exp_fwd.push_back(h);
            else if (h >= int'(MIN_HIGH)) begin
                m_word = {m_word[22:0], (h >= int'(THRESH))};
                m_bits++;
                if (m_bits == 24) begin
                    exp_data = m_word; exp_pv++; m_capt = 1'b1; m_bits = 0;
                end
            end
        end
    endtask

    task automatic model_gap(input int l);
        if (l >= int'(RESET_CYCLES)) begin
            if (m_wait) m_wait = 1'b0;
            else begin
                if (m_bits != 0 || m_capt) exp_fe++;
                if (m_bits != 0 && !m_capt) begin exp_err++; exp_coinc++; end
            end
            m_bits = 0; m_capt = 1'b0;
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        @(negedge clock);
        neopixel_in = 1'b1; rise_cyc = cyc; model_pulse(h);
        repeat (h) @(negedge clock);
        neopixel_in = 1'b0; fall_cyc = cyc;
        repeat (l - 1) @(negedge clock);
        model_gap(l);
    endtask

    task automatic send_bit(input logic b, input int l);
        send_pulse(b ? 35 : 18, (l != 0) ? l : (b ? 30 : 40));
    endtask

    task automatic send_word(input logic [23:0] w, input int last_low);
        for (int i = 23; i >= 0; i--) send_bit(w[i], (i == 0) ? last_low : 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; neopixel_in = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (pixel_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", pixel_data); end
        checks++; if ({pixel_valid, frame_end, error, neopixel_out} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {pixel_valid, frame_end, error, neopixel_out}); end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (pv_cnt + fe_cnt + err_cnt !== 0) begin errors++; $display("FAIL reset_idle: got %0d pulses want 0", pv_cnt + fe_cnt + err_cnt); end
    endtask

    task automatic test_single();
        out_q.delete();
        send_word(24'hA53C0F, 2600);
        checks++; if (pv_cnt !== exp_pv) begin errors++; $display("FAIL single_pv: got %0d want %0d", pv_cnt, exp_pv); end
        checks++; if (pv_data !== exp_data) begin errors++; $display("FAIL single_data: got %h want %h", pv_data, exp_data); end
        // valid is 3 clocks after the edge that samples the final fall
        checks++; if (pv_lat !== 4) begin errors++; $display("FAIL single_pv_lat: got %0d want 4", pv_lat); end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL single_fe: got %0d want %0d", fe_cnt, exp_fe); end
        checks++; if (fe_lat < int'(RESET_CYCLES) + 1 || fe_lat > int'(RESET_CYCLES) + 3) begin
            errors++; $display("FAIL single_fe_lat: got %0d want %0d+-1", fe_lat, RESET_CYCLES + 2); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL single_err: got %0d want %0d", err_cnt, exp_err); end
        checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL single_out: got %0d pulses want 0", out_q.size()); end
    endtask

    task automatic test_forward(input logic [23:0] w1, input logic [23:0] w2);
        int bad_w, bad_d;
        out_q.delete(); dly_q.delete(); exp_fwd.delete();
        send_word(w1, 0);
        send_word(w2, 2600);
        bad_w = 0; bad_d = 0;
        for (int i = 0; i < out_q.size() && i < exp_fwd.size(); i++)
            if (out_q[i] < exp_fwd[i] - 1 || out_q[i] > exp_fwd[i] + 1) bad_w++;
        foreach (dly_q[i]) if (dly_q[i] < 2 || dly_q[i] > 4) bad_d++;
        checks++; if (pv_cnt !== exp_pv) begin errors++; $display("FAIL fwd_pv: got %0d want %0d", pv_cnt, exp_pv); end
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL fwd_data: got %h want %h", pixel_data, exp_data); end
        checks++; if (out_q.size() !== exp_fwd.size()) begin errors++; $display("FAIL fwd_count: got %0d want %0d", out_q.size(), exp_fwd.size()); end
        checks++; if (bad_w !== 0) begin errors++; $display("FAIL fwd_width: got %0d bad widths want 0", bad_w); end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL fwd_delay: got %0d bad delays want 0", bad_d); end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL fwd_fe: got %0d want %0d", fe_cnt, exp_fe); end
    endtask

    task automatic test_boundary();
        logic [23:0] r = 24'($urandom);
        send_pulse(26, 40); send_pulse(27, 30); send_pulse(4, 40); send_pulse(100, 30);
        for (int i = 19; i >= 0; i--) send_bit(r[i], (i == 0) ? 2600 : 0);
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL bnd_data: got %h want %h", pixel_data, exp_data); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL bnd_err: got %0d want %0d", err_cnt, exp_err); end
        send_pulse(101, 30);
        // error at the 101st sampled high cycle, seen through the 2-stage input path
        checks++; if (err_lat !== int'(MAX_HIGH) + 3) begin errors++; $display("FAIL long_err_lat: got %0d want %0d", err_lat, MAX_HIGH + 3); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL long_err: got %0d want %0d", err_cnt, exp_err); end
        send_word(24'($urandom), 2600);
        checks++; if (pv_cnt !== exp_pv) begin errors++; $display("FAIL wait_pv: got %0d want %0d", pv_cnt, exp_pv); end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL wait_fe: got %0d want %0d", fe_cnt, exp_fe); end
        send_word(24'($urandom), 2600);
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL after_wait_data: got %h want %h", pixel_data, exp_data); end
    endtask

    task automatic test_partial();
        logic [23:0] r = 24'($urandom);
        for (int i = 9; i >= 0; i--) send_bit(r[i], (i == 0) ? 2600 : 0);
        checks++; if (coinc_cnt !== exp_coinc) begin errors++; $display("FAIL part_coinc: got %0d want %0d", coinc_cnt, exp_coinc); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL part_err: got %0d want %0d", err_cnt, exp_err); end
        send_word(24'($urandom), 2600);
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL part_next: got %h want %h", pixel_data, exp_data); end
    endtask

    task automatic test_gap();
        logic [23:0] r = 24'($urandom);
        for (int i = 23; i >= 0; i--) send_bit(r[i], (i == 12) ? 2499 : ((i == 0) ? 2600 : 0));
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL gap_data: got %h want %h", pixel_data, exp_data); end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL gap_fe: got %0d want %0d", fe_cnt, exp_fe); end
    endtask

    task automatic test_reset_midframe();
        logic [23:0] r = 24'($urandom);
        for (int i = 23; i >= 9; i--) send_bit(r[i], 0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        checks++; if ({pixel_data, pixel_valid, frame_end, error, neopixel_out} !== 28'h0) begin
            errors++; $display("FAIL mid_reset: got %h/%b want 0", pixel_data, {pixel_valid, frame_end, error, neopixel_out}); end
        m_bits = 0; m_capt = 1'b0; m_wait = 1'b0; exp_data = '0;
        repeat (3) @(negedge clock); reset = 1'b0;
        repeat (50) @(negedge clock);
        send_word(24'($urandom), 2600);
        checks++; if (pixel_data !== exp_data) begin errors++; $display("FAIL mid_data: got %h want %h", pixel_data, exp_data); end
        checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL mid_err: got %0d want %0d", err_cnt, exp_err); end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL mid_fe: got %0d want %0d", fe_cnt, exp_fe); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_forward(24'h123456, 24'hFFFFFF);
        test_forward(24'($urandom), 24'($urandom));
        test_boundary();
        test_partial();
        test_gap();
        test_reset_midframe();
        checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", multi_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neopixel_receiver.md
Name: neopixel_receiver

Overview:
- WS2812-style one-wire decoder: the receiving end of the NeoPixel strand protocol that our low-level controller drives.
- Recovers 24-bit pixel words from the serial line by measuring the width of each high pulse, and detects the latch gap.
- Repeats all bits after the first 24 on a downstream output, the same way a physical pixel does.
- Used as a bench model and as an on-FPGA loopback checker for the strand driver.

Parameters:
- THRESH, 27: high width in cycles at or above which a bit decodes as 1 (T0H = 18, T1H = 35 at 50 MHz).
- MIN_HIGH, 5: high pulses shorter than this are glitches and are ignored.
- MAX_HIGH, 100: high pulses longer than this are protocol errors.
- RESET_CYCLES, 2500: consecutive low cycles that form the latch gap (50 us).
- CW, 12: width of the high and low counters; must satisfy 2^CW > RESET_CYCLES.

Ports:
- clock, in, 1: system clock (50 MHz).
- reset, in, 1: asynchronous, active-high.
- neopixel_in, in, 1: serial line, asynchronous to clock.
- pixel_data, out, 24: last captured word, first-received bit in bit 23.
- pixel_valid, out, 1: one-cycle pulse when pixel_data updates.
- frame_end, out, 1: one-cycle pulse on latch gap.
- error, out, 1: one-cycle pulse on protocol error.
- neopixel_out, out, 1: forwarded serial stream.

Behaviour:
- Interface: reset is reset, asynchronous, active-high; the clock is clock.
- Reset values: all outputs 0, pixel_data = 0, state IDLE, counters 0, bit_cnt 0, captured 0.
- Input path:
  - neopixel_in passes a 2-FF synchronizer to produce s.
  - prev = s delayed by one cycle.
  - rise = s & ~prev; fall = ~s & prev.
  - All decoding uses s only.
- States:
  - IDLE / LOW: line low, counting low_cnt.
    - On rise: high_cnt <= 1, go to HIGH.
    - Each low cycle: low_cnt increments, saturating.
    - When low_cnt reaches RESET_CYCLES with s still low: if bit_cnt != 0 or captured, pulse frame_end.
    - On that pulse: if bit_cnt is 1..23 and not captured, also pulse error.
    - Also clear bit_cnt and captured, and go to IDLE.
    - A rise before RESET_CYCLES clears low_cnt and produces no frame_end.
  - HIGH: high_cnt increments each cycle s = 1.
    - If high_cnt exceeds MAX_HIGH: pulse error, clear bit_cnt, go to WAIT_GAP. A stuck-high line therefore errors exactly once.
    - On fall with w = high_cnt:
      - w < MIN_HIGH: discard the pulse and return to LOW; low_cnt continues from 0.
      - Otherwise bit = (w >= THRESH), and go to LOW with low_cnt = 1.
    - If not captured: shift the bit into the 24-bit shift register MSB-first and increment bit_cnt.
    - On the 24th bit: pixel_data <= shift register with the new bit included, pixel_valid pulses on the next cycle, captured <= 1, bit_cnt <= 0.
    - If captured: the bit is not stored; it is only forwarded.
  - WAIT_GAP: ignores all pulses.
    - Counts consecutive low cycles; reaching RESET_CYCLES returns to IDLE, clears captured, and produces no frame_end.
    - Any rise restarts the count.
- Latency:
  - pixel_valid is high exactly 3 clocks after the clock edge that first samples neopixel_in low at the end of the 24th bit.
  - frame_end rises RESET_CYCLES+2 clocks after neopixel_in goes low, ±1 for synchronizer phase.
- Forwarding: neopixel_out = s when captured = 1 and state != WAIT_GAP, else 0.
  - The 24th bit itself is not forwarded.
  - Forwarding begins with the rising edge of bit 25.
- pixel_data holds its value until the next complete word; it is not cleared by frame_end or error.
- pixel_valid, frame_end and error are never asserted for more than one consecutive cycle.
  - pixel_valid and frame_end cannot coincide, because frame_end requires RESET_CYCLES of low.
  - error may coincide with frame_end (partial word).
- Reset asserted mid-frame clears everything asynchronously.
  - If the line is high when reset releases, that pulse is ignored: no rise was seen, so its fall is ignored in IDLE.

Test Plan:
- Drive 24 bits 0xA5_3C_0F (1: 35 high / 30 low; 0: 18 high / 40 low), then 2500 low. Required: pixel_data = 0xA53C0F, one pixel_valid pulse 3 cycles after the last fall, frame_end once, error never, neopixel_out stays 0.
- Drive 48 bits, 0x123456 then 0xFFFFFF, then a gap. Required:
  - pixel_data = 0x123456.
  - neopixel_out reproduces the second 24 pulses delayed 2 cycles with widths ±1.
  - Only one pixel_valid pulse.
- Boundary widths: 26 high gives bit 0, 27 gives 1, 4-cycle pulse ignored (bit_cnt unchanged), 101 gives error at cycle 101 of high and then WAIT_GAP. A following word is accepted only after a 2500-cycle gap.
- Send 10 bits then a 2500 gap. Required: frame_end and error pulse together, and the next 24 bits decode correctly from bit_cnt 0.
- Low gap of 2499 cycles between bits 12 and 13: no frame_end, and the word completes normally.
- Assert reset after bit 15, release with the line low, then send a full word. Required: outputs 0 during reset, the new word decodes with no residue from earlier bits.
